// File: rtl/fpga_config_loader.sv
// Byte-stream bitstream receiver that assembles frames and strobes them into the fpga fabric.
// Optional trailer checksum: define CFG_CHECKSUM_EN.
module fpga_config_loader #(
  parameter int unsigned FRAME_W    = 320,
  parameter int unsigned NUM_FRAMES = 172,
  parameter int unsigned SETTLE_CYC = 10
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic                            start,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [FRAME_W-1:0]              configs_in,
  output logic [NUM_FRAMES-1:0]           configs_en,
  output logic                            ff_en,
  output logic                            rdy,
  output logic                            err,
  output logic [$clog2(NUM_FRAMES+1)-1:0] frame_cnt
);

  localparam int unsigned BYTES = FRAME_W / 8;
  localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CW    = $clog2(NUM_FRAMES + 1);
  localparam int unsigned SCW   = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_WRITE, S_SETTLE, S_DONE
`ifdef CFG_CHECKSUM_EN
    , S_CHECK, S_ERROR
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [FRAME_W-1:0]    shift_q, shift_d;
  logic [FRAME_W-1:0]    configs_in_q, configs_in_d;
  logic [NUM_FRAMES-1:0] configs_en_q, configs_en_d;
  logic [CW-1:0]         frame_cnt_q, frame_cnt_d;
  logic [SCW-1:0]        settle_q, settle_d;
  logic                  ff_en_q, ff_en_d;
  logic                  rdy_q, rdy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  accept;
  logic                  restart;
`ifdef CFG_CHECKSUM_EN
  logic [15:0]           sum_q, sum_d;
  logic [7:0]            trail_hi_q, trail_hi_d;
  logic                  err_q, err_d;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    configs_in_d = configs_in_q;
    frame_cnt_d  = frame_cnt_q;
    settle_d     = settle_q;
    ff_en_d      = ff_en_q;
    rdy_d        = rdy_q;
`ifdef CFG_CHECKSUM_EN
    sum_d        = sum_q;
    trail_hi_d   = trail_hi_q;
    err_d        = err_q;
`endif
    accept  = in_valid && in_ready_q;
    restart = 1'b0;

    case (state_q)
      S_IDLE: restart = start;
      S_SHIFT: begin
        if (accept) begin
          shift_d = {shift_q[FRAME_W-9:0], in_data};
`ifdef CFG_CHECKSUM_EN
          sum_d = sum_q + 16'(in_data);
`endif
          if (byte_cnt_q == BCW'(BYTES - 1)) begin
            configs_in_d = {shift_q[FRAME_W-9:0], in_data};
            byte_cnt_d   = '0;
            state_d      = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
      S_WRITE: begin
        frame_cnt_d = frame_cnt_q + CW'(1);
        if (frame_cnt_q == CW'(NUM_FRAMES - 1)) begin
`ifdef CFG_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d  = S_SETTLE;
          settle_d = '0;
`endif
        end else begin
          state_d = S_SHIFT;
        end
      end
`ifdef CFG_CHECKSUM_EN
      // Two trailer bytes, high byte first, compared against the running sum.
      S_CHECK: begin
        if (accept) begin
          if (byte_cnt_q == '0) begin
            trail_hi_d = in_data;
            byte_cnt_d = BCW'(1);
          end else if ({trail_hi_q, in_data} == sum_q) begin
            state_d  = S_SETTLE;
            settle_d = '0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_ERROR: restart = start;
`endif
      S_SETTLE: begin
        if (settle_q == SCW'(SETTLE_CYC - 1)) begin
          state_d = S_DONE;
          ff_en_d = 1'b1;
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        restart = start;
      end
      default: state_d = S_IDLE;
    endcase

    // configs_in deliberately keeps its previous frame across a restart.
    if (restart) begin
      state_d     = S_SHIFT;
      byte_cnt_d  = '0;
      frame_cnt_d = '0;
      ff_en_d     = 1'b0;
      rdy_d       = 1'b0;
`ifdef CFG_CHECKSUM_EN
      sum_d       = '0;
      err_d       = 1'b0;
`endif
    end

    configs_en_d = (state_d == S_WRITE) ? (NUM_FRAMES'(1) << frame_cnt_q) : '0;
`ifdef CFG_CHECKSUM_EN
    in_ready_d = (state_d == S_SHIFT) || (state_d == S_CHECK);
`else
    in_ready_d = (state_d == S_SHIFT);
`endif
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      configs_in_q <= '0;
      configs_en_q <= '0;
      frame_cnt_q  <= '0;
      settle_q     <= '0;
      ff_en_q      <= 1'b0;
      rdy_q        <= 1'b0;
      in_ready_q   <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      sum_q        <= '0;
      trail_hi_q   <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      configs_in_q <= configs_in_d;
      configs_en_q <= configs_en_d;
      frame_cnt_q  <= frame_cnt_d;
      settle_q     <= settle_d;
      ff_en_q      <= ff_en_d;
      rdy_q        <= rdy_d;
      in_ready_q   <= in_ready_d;
`ifdef CFG_CHECKSUM_EN
      sum_q        <= sum_d;
      trail_hi_q   <= trail_hi_d;
      err_q        <= err_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign configs_in = configs_in_q;
  assign configs_en = configs_en_q;
  assign frame_cnt  = frame_cnt_q;
  assign ff_en      = ff_en_q;
  assign rdy        = rdy_q;
`ifdef CFG_CHECKSUM_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader: frames pushed when driven, popped on each configs_en strobe.
module tb_fpga_config_loader;

  localparam int unsigned FRAME_W    = 320;
  localparam int unsigned NUM_FRAMES = 172;
  localparam int unsigned SETTLE_CYC = 10;
  localparam int unsigned BYTES      = FRAME_W / 8;
  localparam int unsigned CW         = $clog2(NUM_FRAMES + 1);

  logic                  clock = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic [7:0]            in_data = 8'h00;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [FRAME_W-1:0]    configs_in;
  logic [NUM_FRAMES-1:0] configs_en;
  logic                  ff_en;
  logic                  rdy;
  logic                  err;
  logic [CW-1:0]         frame_cnt;

  fpga_config_loader #(
    .FRAME_W(FRAME_W), .NUM_FRAMES(NUM_FRAMES), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .configs_in(configs_in), .configs_en(configs_en),
    .ff_en(ff_en), .rdy(rdy), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int                 idx;
    logic [FRAME_W-1:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_writes = 0;
  int          last_wr_cyc = 0;
  int          ff_rise_cyc = -1;
  int          rdy_rise_cyc = -1;
  int          exp_idx = 0;
  logic        ff_prev = 1'b0;
  logic        rdy_prev = 1'b0;
  logic [15:0] sum = 16'h0;

  always @(posedge clock) cyc++;

  // Write-strobe monitor: pops the scoreboard on every configs_en pulse.
  always @(negedge clock) begin
    if (rst) begin
      if (configs_en != '0) begin
        n_writes++;
        last_wr_cyc = cyc;
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: configs_en=%h with no frame pending", configs_en);
        end else begin
          mon_e = sb.pop_front();
          n_chk++;
          if (configs_en !== (NUM_FRAMES'(1) << mon_e.idx)) begin
            n_fail++;
            $display("FAIL write_strobe: got %h want bit %0d", configs_en, mon_e.idx);
          end
          n_chk++;
          if (configs_in !== mon_e.data) begin
            n_fail++;
            $display("FAIL frame_data[%0d]: got %h want %h", mon_e.idx, configs_in, mon_e.data);
          end
          n_chk++;
          if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_write: in_ready=%b want 0", in_ready);
          end
        end
      end
      if (ff_en && !ff_prev) ff_rise_cyc = cyc;
      if (rdy && !rdy_prev) rdy_rise_cyc = cyc;
    end
    ff_prev  = ff_en;
    rdy_prev = rdy;
  end

  task automatic pulse_start;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Holds a byte until it is accepted; optional random valid gaps with junk data.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    bit acc;
    guard = 0;
    do begin
      @(negedge clock);
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      acc = in_valid && in_ready;
      guard++;
    end while (!acc && guard < 500);
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_timeout: in_ready=%b after %0d cycles, want 1", in_ready, guard);
    end
  endtask

  task automatic send_frame(input bit gaps, input int nbytes, input bit ramp);
    logic [FRAME_W-1:0] f;
    logic [7:0]         b;
    f = '0;
    for (int i = 0; i < int'(BYTES); i++)
      f = {f[FRAME_W-9:0], (ramp ? 8'(i + 1) : 8'($urandom))};
    if (nbytes == int'(BYTES)) begin
      sb.push_back('{idx: exp_idx, data: f});
      exp_idx++;
    end
    for (int i = 0; i < nbytes; i++) begin
      b = f[FRAME_W-1-8*i -: 8];
      sum = sum + 16'(b);
      send_byte(b, gaps);
    end
  endtask

  task automatic release_bus;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_sb;
    sb.delete();
    exp_idx  = 0;
    n_writes = 0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) @(negedge clock);
    n_chk++; if (configs_in !== '0) begin n_fail++; $display("FAIL rst_configs_in: got %h want 0", configs_in); end
    n_chk++; if (configs_en !== '0) begin n_fail++; $display("FAIL rst_configs_en: got %h want 0", configs_en); end
    n_chk++; if (ff_en !== 1'b0) begin n_fail++; $display("FAIL rst_ff_en: got %b want 0", ff_en); end
    n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy: got %b want 0", rdy); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_chk++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_chk++;
      if (in_ready !== 1'b0 || frame_cnt !== '0) begin
        n_fail++;
        $display("FAIL idle_no_start: in_ready=%b frame_cnt=%0d want 0/0", in_ready, frame_cnt);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single_frame;
    clear_sb();
    pulse_start();
    send_frame(1'b0, BYTES, 1'b1);
    release_bus();
    repeat (2) @(negedge clock);
    n_chk++; if (configs_in[FRAME_W-1 -: 8] !== 8'h01) begin n_fail++; $display("FAIL single_msb: got %h want 01", configs_in[FRAME_W-1 -: 8]); end
    n_chk++; if (configs_in[7:0] !== 8'h28) begin n_fail++; $display("FAIL single_lsb: got %h want 28", configs_in[7:0]); end
    n_chk++; if (n_writes !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", n_writes); end
    n_chk++; if (frame_cnt !== CW'(1)) begin n_fail++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
    n_chk++; if (configs_en !== '0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL single_after_write: en=%h rdy_in=%b want 0/1", configs_en, in_ready); end
    rst = 1'b0;
    repeat (2) @(negedge clock);
    clear_sb();
    rst = 1'b1;
  endtask

  // Full load; delta offsets the checksum trailer (checksum builds only).
  task automatic test_full_load(input bit gaps, input int delta);
    int guard;
    clear_sb();
    sum = 16'h0;
    ff_rise_cyc  = -1;
    rdy_rise_cyc = -1;
    pulse_start();
    n_chk++;
    if (frame_cnt !== '0 || rdy !== 1'b0 || ff_en !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clears: frame_cnt=%0d rdy=%b ff_en=%b err=%b want all 0", frame_cnt, rdy, ff_en, err);
    end
    for (int f = 0; f < int'(NUM_FRAMES); f++) send_frame(gaps, BYTES, 1'b0);
`ifdef CFG_CHECKSUM_EN
    begin
      logic [15:0] trailer;
      trailer = sum + 16'(delta);
      send_byte(trailer[15:8], gaps);
      send_byte(trailer[7:0], gaps);
    end
`endif
    release_bus();
    guard = 0;
    while (!(ff_en || err) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    repeat (3) @(negedge clock);
    n_chk++; if (n_writes !== int'(NUM_FRAMES)) begin n_fail++; $display("FAIL load_pulses: got %0d want %0d", n_writes, NUM_FRAMES); end
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL load_pending: %0d frames never written, want 0", sb.size()); end
    n_chk++; if (frame_cnt !== CW'(NUM_FRAMES)) begin n_fail++; $display("FAIL load_frame_cnt: got %0d want %0d", frame_cnt, NUM_FRAMES); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_in_ready: got %b want 0", in_ready); end
`ifdef CFG_CHECKSUM_EN
    if (delta != 0) begin
      n_chk++;
      if (err !== 1'b1 || ff_en !== 1'b0 || rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_trailer: err=%b ff_en=%b rdy=%b want 1/0/0", err, ff_en, rdy);
      end
    end else begin
      n_chk++;
      if (err !== 1'b0 || ff_en !== 1'b1 || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL good_trailer: err=%b ff_en=%b rdy=%b want 0/1/1", err, ff_en, rdy);
      end
      n_chk++;
      if (rdy_rise_cyc - ff_rise_cyc !== 1) begin n_fail++; $display("FAIL rdy_lag: got %0d want 1", rdy_rise_cyc - ff_rise_cyc); end
    end
`else
    n_chk++;
    if (err !== 1'b0 || ff_en !== 1'b1 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done: err=%b ff_en=%b rdy=%b want 0/1/1", err, ff_en, rdy);
    end
    n_chk++;
    if (ff_rise_cyc - last_wr_cyc !== int'(SETTLE_CYC) + 1) begin
      n_fail++;
      $display("FAIL settle_delay: got %0d want %0d", ff_rise_cyc - last_wr_cyc, SETTLE_CYC + 1);
    end
    n_chk++;
    if (rdy_rise_cyc - ff_rise_cyc !== 1) begin n_fail++; $display("FAIL rdy_lag: got %0d want 1", rdy_rise_cyc - ff_rise_cyc); end
`endif
  endtask

  task automatic test_reset_mid;
    clear_sb();
    sum = 16'h0;
    pulse_start();
    for (int f = 0; f < 5; f++) send_frame(1'b0, BYTES, 1'b0);
    send_frame(1'b0, 13, 1'b0);
    @(posedge clock);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_chk++;
    if (configs_in !== '0 || configs_en !== '0 || ff_en !== 1'b0 || rdy !== 1'b0 ||
        err !== 1'b0 || frame_cnt !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: cfg=%h en=%h ff=%b rdy=%b err=%b cnt=%0d ir=%b want all 0",
               configs_in, configs_en, ff_en, rdy, err, frame_cnt, in_ready);
    end
    n_chk++; if (n_writes !== 5) begin n_fail++; $display("FAIL mid_pulses: got %0d want 5", n_writes); end
    repeat (2) @(negedge clock);
    clear_sb();
    rst = 1'b1;
    test_full_load(1'b0, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_full_load(1'b0, 0);
    test_full_load(1'b1, 0);
    test_reset_mid();
`ifdef CFG_CHECKSUM_EN
    test_full_load(1'b1, 1);
    test_full_load(1'b0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
